// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single-access SDRAM controller: latches one request,
// issues it, follows the controller's busy handshake and returns a one-cycle ack.
module sdram_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_p0_rd_enable,
  input  logic        i_p0_wr_enable,
  input  logic [25:0] i_p0_address,
  input  logic [1:0]  i_p0_size,
  input  logic [63:0] i_p0_write_data,
  output logic        o_p0_ack,
  output logic [63:0] o_p0_read_data,
  input  logic        i_p1_rd_enable,
  input  logic        i_p1_wr_enable,
  input  logic [25:0] i_p1_address,
  input  logic [1:0]  i_p1_size,
  input  logic [63:0] i_p1_write_data,
  output logic        o_p1_ack,
  output logic [63:0] o_p1_read_data,
  output logic        o_mem_rd_enable,
  output logic        o_mem_wr_enable,
  output logic [25:0] o_mem_address,
  output logic [1:0]  o_mem_size,
  output logic [63:0] o_mem_write_data,
  input  logic        i_mem_busy,
  input  logic [63:0] i_mem_read_data,
  output logic        o_grant,
  output logic        o_arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_grant;
  logic        r_last_grant;
  logic        r_is_write;
  logic [25:0] r_address;
  logic [1:0]  r_size;
  logic [63:0] r_write_data;
  logic [63:0] r_p0_read_data;
  logic [63:0] r_p1_read_data;

  logic w_p0_pending;
  logic w_p1_pending;
  logic w_take;
  logic w_sel;
  logic w_capture;

  assign w_p0_pending = i_p0_rd_enable | i_p0_wr_enable;
  assign w_p1_pending = i_p1_rd_enable | i_p1_wr_enable;
  assign w_take       = (r_state == S_IDLE) && (w_p0_pending || w_p1_pending);
  assign w_capture    = (r_state == S_WAIT) && !i_mem_busy && !r_is_write;

  // On contention round-robin favours the port that did not win last time.
  always_comb begin
    w_sel = 1'b0;
    if (w_p0_pending && w_p1_pending) begin
      w_sel = (FIXED_PRIORITY != 0) ? 1'b0 : ~r_last_grant;
    end else begin
      w_sel = w_p1_pending;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (!i_mem_busy) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Enables follow busy in WAIT so the controller never sees a request once it returns to idle.
  always_comb begin
    o_mem_rd_enable = 1'b0;
    o_mem_wr_enable = 1'b0;
    o_p0_ack        = 1'b0;
    o_p1_ack        = 1'b0;
    o_arb_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_arb_busy = 1'b0;
      end
      S_ISSUE: begin
        o_mem_rd_enable = !r_is_write;
        o_mem_wr_enable = r_is_write;
      end
      S_WAIT: begin
        o_mem_rd_enable = !r_is_write && i_mem_busy;
        o_mem_wr_enable = r_is_write && i_mem_busy;
      end
      S_DONE: begin
        o_p0_ack = !r_grant;
        o_p1_ack = r_grant;
      end
      default: begin
        o_arb_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_is_write     <= 1'b0;
      r_address      <= '0;
      r_size         <= '0;
      r_write_data   <= '0;
      r_p0_read_data <= '0;
      r_p1_read_data <= '0;
    end else begin
      if (w_take) begin
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        if (w_sel) begin
          r_is_write   <= i_p1_wr_enable;
          r_address    <= i_p1_address;
          r_size       <= i_p1_size;
          r_write_data <= i_p1_write_data;
        end else begin
          r_is_write   <= i_p0_wr_enable;
          r_address    <= i_p0_address;
          r_size       <= i_p0_size;
          r_write_data <= i_p0_write_data;
        end
      end
      if (w_capture) begin
        if (r_grant) begin
          r_p1_read_data <= i_mem_read_data;
        end else begin
          r_p0_read_data <= i_mem_read_data;
        end
      end
    end
  end

  assign o_mem_address    = r_address;
  assign o_mem_size       = r_size;
  assign o_mem_write_data = r_write_data;
  assign o_p0_read_data   = r_p0_read_data;
  assign o_p1_read_data   = r_p1_read_data;
  assign o_grant          = r_grant;

endmodule
